// File: rtl/sensor_request_scheduler.sv
// Round-robin scheduler sharing one sensor connection between NUM_REQ requesters.
// Optional WAIT watchdog is compiled in with `define SENSOR_SCHED_TIMEOUT_EN.
module sensor_request_scheduler #(
  parameter int NUM_REQ        = 2,
  parameter int MIN_GAP_CYCLES = 100000000,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int CNT_W          = 27
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_command,
  input  logic [8*NUM_REQ-1:0] req_address,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [7:0]           resp_command,
  output logic [7:0]           resp_value,
  output logic                 busy,
  output logic                 sens_enable,
  output logic [7:0]           sens_command,
  output logic [7:0]           sens_address,
  input  logic                 sens_done,
  input  logic [7:0]           sens_resp_command,
  input  logic [7:0]           sens_resp_value
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'((MIN_GAP_CYCLES > 0) ? MIN_GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_SAT =
    CNT_W'((MIN_GAP_CYCLES > TIMEOUT_CYCLES) ? MIN_GAP_CYCLES : TIMEOUT_CYCLES);
`ifdef SENSOR_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DELIVER, S_GAP
  } state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   ptr_reg;
  logic [IDX_W-1:0]   winner_reg;
  logic               is_sensor_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [NUM_REQ-1:0] resp_valid_reg;
  logic [7:0]         resp_command_reg;
  logic [7:0]         resp_value_reg;
  logic               busy_reg;
  logic               sens_enable_reg;
  logic [7:0]         sens_command_reg;
  logic [7:0]         sens_address_reg;

  logic [7:0] cmd_arr  [NUM_REQ];
  logic [7:0] addr_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign cmd_arr[gi]  = req_command[8*gi +: 8];
      assign addr_arr[gi] = req_address[8*gi +: 8];
    end
  endgenerate

  // First set request at or after the pointer; scanning downward leaves the nearest one.
  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= S_IDLE;
      ptr_reg          <= '0;
      winner_reg       <= '0;
      is_sensor_reg    <= 1'b0;
      cnt_reg          <= '0;
      resp_valid_reg   <= '0;
      resp_command_reg <= '0;
      resp_value_reg   <= '0;
      busy_reg         <= 1'b0;
      sens_enable_reg  <= 1'b0;
      sens_command_reg <= '0;
      sens_address_reg <= '0;
    end else begin
      resp_valid_reg <= '0;
      case (state_reg)
        S_IDLE: begin
          if (grant_found) begin
            winner_reg       <= grant_idx;
            ptr_reg          <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            sens_command_reg <= cmd_arr[grant_idx];
            sens_address_reg <= addr_arr[grant_idx];
            busy_reg         <= 1'b1;
            if (cmd_arr[grant_idx] <= 8'h02) begin
              is_sensor_reg <= 1'b1;
              state_reg     <= S_ISSUE;
            end else begin
              // Continuous/unknown commands are refused without touching the sensor.
              is_sensor_reg    <= 1'b0;
              resp_command_reg <= 8'hAA;
              resp_value_reg   <= 8'hAA;
              resp_valid_reg   <= onehot(grant_idx);
              state_reg        <= S_DELIVER;
            end
          end
        end
        S_ISSUE: begin
          sens_enable_reg <= 1'b1;
          cnt_reg         <= '0;
          state_reg       <= S_WAIT;
        end
        S_WAIT: begin
          if (sens_done) begin
            resp_command_reg <= sens_resp_command;
            resp_value_reg   <= sens_resp_value;
            resp_valid_reg   <= onehot(winner_reg);
            sens_enable_reg  <= 1'b0;
            state_reg        <= S_DELIVER;
`ifdef SENSOR_SCHED_TIMEOUT_EN
          end else if (cnt_reg >= TIMEOUT_LAST) begin
            resp_command_reg <= 8'h1F;
            resp_value_reg   <= 8'h1F;
            resp_valid_reg   <= onehot(winner_reg);
            sens_enable_reg  <= 1'b0;
            state_reg        <= S_DELIVER;
`endif
          end else if (cnt_reg < CNT_SAT) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_DELIVER: begin
          cnt_reg <= '0;
          if (is_sensor_reg) begin
            state_reg <= S_GAP;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        S_GAP: begin
          if (cnt_reg >= GAP_LAST) begin
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end else if (cnt_reg < CNT_SAT) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign resp_valid   = resp_valid_reg;
  assign resp_command = resp_command_reg;
  assign resp_value   = resp_value_reg;
  assign busy         = busy_reg;
  assign sens_enable  = sens_enable_reg;
  assign sens_command = sens_command_reg;
  assign sens_address = sens_address_reg;

endmodule

// File: tb/tb_sensor_request_scheduler.sv
// Bench for sensor_request_scheduler: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-timeline model.
module tb_sensor_request_scheduler;

  localparam int N       = 2;
  localparam int GAP     = 20;
  localparam int TIMEOUT = 50;
  localparam int NEVER   = 32'h3fffffff;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = '0;
  logic [15:0] req_command = '0;
  logic [15:0] req_address = '0;
  logic [1:0]  resp_valid;
  logic [7:0]  resp_command, resp_value;
  logic        busy, sens_enable;
  logic [7:0]  sens_command, sens_address;
  logic        sens_done = 1'b0;
  logic [7:0]  sens_resp_command = '0;
  logic [7:0]  sens_resp_value = '0;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  sensor_request_scheduler #(
    .NUM_REQ(N), .MIN_GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(8)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .req_command(req_command),
    .req_address(req_address), .resp_valid(resp_valid), .resp_command(resp_command),
    .resp_value(resp_value), .busy(busy), .sens_enable(sens_enable),
    .sens_command(sens_command), .sens_address(sens_address), .sens_done(sens_done),
    .sens_resp_command(sens_resp_command), .sens_resp_value(sens_resp_value)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait expired at %0t", name, $time);
  endtask

  // ---------------- sensor connection emulator ----------------
  int       done_delay = 3;
  bit       rand_delay = 1'b0;
  bit       hang = 1'b0;
  bit       use_fixed = 1'b0;
  logic [7:0] fix_c = '0, fix_v = '0;
  int       en_cnt = 0;

  initial forever begin
    @(posedge clock);
    #1;
    if (!sens_enable) begin
      sens_done = 1'b0;
      en_cnt    = 0;
      if (rand_delay) done_delay = $urandom_range(0, 6);
    end else begin
      if (!hang && !sens_done && en_cnt >= done_delay) begin
        sens_done = 1'b1;
        if (use_fixed) begin
          sens_resp_command = fix_c;
          sens_resp_value   = fix_v;
        end else begin
          sens_resp_command = 8'($urandom);
          sens_resp_value   = 8'($urandom);
        end
      end
      en_cnt++;
    end
  end

  // ---------------- transaction-timeline model ----------------
  // Per grant edge t: sensor commands raise enable from t+1 until the first edge >= t+2
  // that sees done; the response shows in that same cycle, then the scheduler is
  // blocked for the gap. Rejected commands answer in cycle t and free at t+2.
  int   m_n = 0;
  int   m_samp = 0;
  int   m_en_from = -1, m_en_to = -1, m_resp_edge = -1;
  bit   m_open = 1'b0;
  int   m_ptr = 0, m_win = 0;
  logic [7:0] m_cmd = '0, m_addr = '0, m_rc = '0, m_rv = '0;
  logic       exp_en = 1'b0, exp_busy = 1'b0;
  logic [1:0] exp_rv = '0;

  task automatic model_close(input logic [7:0] c, input logic [7:0] v);
    m_en_to     = m_n;
    m_resp_edge = m_n;
    m_rc        = c;
    m_rv        = v;
    m_samp      = m_n + ((GAP > 0) ? GAP : 1) + 2;
    m_open      = 1'b0;
  endtask

  initial forever begin
    @(posedge clock);
    m_n++;
    if (reset) begin
      m_ptr = 0; m_samp = m_n + 1; m_open = 1'b0;
      m_en_from = -1; m_en_to = -1; m_resp_edge = -1;
      m_cmd = '0; m_addr = '0; m_rc = '0; m_rv = '0;
    end else if (m_open && m_n >= m_en_from + 1 && sens_done) begin
      model_close(sens_resp_command, sens_resp_value);
`ifdef SENSOR_SCHED_TIMEOUT_EN
    end else if (m_open && m_n == m_en_from + TIMEOUT) begin
      model_close(8'h1F, 8'h1F);
`endif
    end else if (!m_open && m_n >= m_samp && req != '0) begin
      for (int k = N - 1; k >= 0; k--)
        if (req[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
      m_ptr  = (m_win + 1) % N;
      m_cmd  = req_command[8*m_win +: 8];
      m_addr = req_address[8*m_win +: 8];
      if (m_cmd <= 8'h02) begin
        m_open = 1'b1; m_en_from = m_n + 1; m_en_to = -1; m_samp = NEVER;
      end else begin
        m_resp_edge = m_n; m_rc = 8'hAA; m_rv = 8'hAA;
        m_samp = m_n + 2; m_en_from = -1;
      end
    end
    exp_en   = (m_en_from >= 0) && (m_n >= m_en_from) && (m_open || m_n < m_en_to);
    exp_busy = (m_n < m_samp - 1);
    exp_rv   = (m_n == m_resp_edge) ? 2'(1 << m_win) : 2'b00;
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      chk("sens_enable", sens_enable, exp_en);
      chk("busy", busy, exp_busy);
      chk("resp_valid", resp_valid, exp_rv);
      chk("sens_command", sens_command, m_cmd);
      chk("sens_address", sens_address, m_addr);
      if (exp_rv != 2'b00) begin
        chk("resp_command", resp_command, m_rc);
        chk("resp_value", resp_value, m_rv);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic bit cond(input int sel);
    case (sel)
      0:       return sens_enable == 1'b1;
      1:       return sens_enable == 1'b0;
      2:       return busy == 1'b0;
      default: return resp_valid != 2'b00;
    endcase
  endfunction

  // Counts sampled cycles where the condition was false before the one where it holds.
  task automatic wait_sig(input int sel, input int budget, input string name, output int cnt);
    cnt = 0;
    while (1) begin
      @(negedge clock);
      if (cond(sel)) break;
      cnt++;
      if (cnt >= budget) begin
        timeout_fail(name);
        break;
      end
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] c, input logic [7:0] a);
    req_command[8*i +: 8] = c;
    req_address[8*i +: 8] = a;
    req[i] = 1'b1;
  endtask

  task automatic go_idle();
    int c;
    wait_sig(2, 500, "idle_wait", c);
    @(posedge clock); #1;
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic take_resp(output logic [1:0] who);
    int c;
    wait_sig(3, 500, "resp_wait", c);
    who = resp_valid;
    @(posedge clock); #1;
    req = req & ~who;
  endtask

  task automatic requester(input int i, input int count);
    int dly, r, w;
    logic [7:0] c;
    for (int k = 0; k < count; k++) begin
      dly = $urandom_range(0, 6);
      repeat (dly) @(posedge clock);
      #1;
      r = $urandom_range(0, 9);
      if (r < 7)       c = 8'(r % 3);
      else if (r == 7) c = 8'($urandom_range(3, 6));
      else             c = 8'($urandom_range(7, 255));
      set_req(i, c, 8'($urandom));
      w = 0;
      while (1) begin
        @(negedge clock);
        if (resp_valid[i]) break;
        w++;
        if (w > 3000) begin
          timeout_fail("rand_resp_wait");
          break;
        end
      end
      @(posedge clock); #1;
      req[i] = 1'b0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c, w;
    logic [1:0] who;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk_en = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_sens_enable", sens_enable, 1'b0);
    chk("rst_resp_valid", resp_valid, 2'b00);
    @(posedge clock); #1;

    // 1: single sensor read, done 5 cycles after enable
    done_delay = 5; use_fixed = 1'b1; fix_c = 8'h09; fix_v = 8'h19;
    set_req(0, 8'h01, 8'h40);
    wait_sig(0, 50, "t1_enable_wait", c);
    chk("t1_enable_latency", c, 2);
    wait_sig(1, 100, "t1_enable_fall", w);
    chk("t1_enable_width", w + 1, 6);
    chk("t1_resp_valid", resp_valid, 2'b01);
    chk("t1_resp_command", resp_command, 8'h09);
    chk("t1_resp_value", resp_value, 8'h19);
    chk("t1_sens_address", sens_address, 8'h40);
    @(posedge clock); #1 req[0] = 1'b0;
    wait_sig(2, 100, "t1_gap", c);
    chk("t1_gap_cycles", c, 20);
    @(posedge clock); #1;

    // 2: simultaneous requests from reset, pointer rotation
    pulse_reset();
    @(negedge clock);
    chk("t2_rst_resp_command", resp_command, 8'h00);
    chk("t2_rst_resp_value", resp_value, 8'h00);
    chk("t2_rst_sens_command", sens_command, 8'h00);
    @(posedge clock); #1;
    use_fixed = 1'b0; done_delay = 3;
    set_req(0, 8'h02, 8'h11);
    set_req(1, 8'h02, 8'h22);
    take_resp(who); chk("t2_first", who, 2'b01);
    take_resp(who); chk("t2_second", who, 2'b10);
    go_idle();
    set_req(0, 8'h02, 8'h11);
    set_req(1, 8'h02, 8'h22);
    take_resp(who); chk("t2_third", who, 2'b01);
    take_resp(who); chk("t2_fourth", who, 2'b10);
    go_idle();

    // 3: continuous-mode command is rejected without touching the sensor
    set_req(1, 8'h03, 8'h33);
    wait_sig(3, 50, "t3_resp_wait", c);
    chk("t3_latency", c, 1);
    chk("t3_resp_valid", resp_valid, 2'b10);
    chk("t3_resp_command", resp_command, 8'hAA);
    chk("t3_resp_value", resp_value, 8'hAA);
    chk("t3_sens_enable", sens_enable, 1'b0);
    @(posedge clock); #1 req[1] = 1'b0;
    go_idle();

    // 6: requester drops req during WAIT; response still delivered, gap follows
    use_fixed = 1'b1; fix_c = 8'h08; fix_v = 8'h30; done_delay = 4;
    set_req(0, 8'h02, 8'h66);
    wait_sig(0, 50, "t6_enable_wait", c);
    @(posedge clock); #1 req[0] = 1'b0;
    wait_sig(3, 100, "t6_resp_wait", c);
    chk("t6_resp_valid", resp_valid, 2'b01);
    chk("t6_resp_command", resp_command, 8'h08);
    chk("t6_resp_value", resp_value, 8'h30);
    @(negedge clock);
    chk("t6_gap_busy", busy, 1'b1);
    go_idle();

`ifdef SENSOR_SCHED_TIMEOUT_EN
    // 5: sensor never answers -> abort after TIMEOUT WAIT cycles
    hang = 1'b1;
    set_req(0, 8'h01, 8'h55);
    wait_sig(0, 50, "t5_enable_wait", c);
    wait_sig(1, 200, "t5_enable_fall", w);
    chk("t5_enable_width", w + 1, 50);
    chk("t5_resp_valid", resp_valid, 2'b01);
    chk("t5_resp_command", resp_command, 8'h1F);
    chk("t5_resp_value", resp_value, 8'h1F);
    @(posedge clock); #1 req[0] = 1'b0;
    hang = 1'b0;
    go_idle();
`endif

    // 4: reset during WAIT, then the held request issues with no gap
    hang = 1'b1;
    set_req(0, 8'h00, 8'h44);
    wait_sig(0, 50, "t4_enable_wait", c);
    repeat (3) @(negedge clock);
    pulse_reset();
    @(negedge clock);
    chk("t4_sens_enable", sens_enable, 1'b0);
    chk("t4_busy", busy, 1'b0);
    chk("t4_resp_valid", resp_valid, 2'b00);
    hang = 1'b0; use_fixed = 1'b0; done_delay = 2;
    wait_sig(0, 50, "t4_reissue_wait", c);
    chk("t4_reissue_latency", c, 1);
    take_resp(who);
    chk("t4_resp", who, 2'b01);
    go_idle();

    // randomized traffic from both requesters
    rand_delay = 1'b1;
    fork
      requester(0, 15);
      requester(1, 15);
    join
    go_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
